// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute controller for the single-issue core.
// Owns pc and ir, addresses the instruction ROM, gates the decoder's
// register-file write enable, and implements SLP (tick-counted sleep)
// and JMP (absolute pc load).
module cpu_sequencer #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 14,
    parameter int SLP_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [30:0]       imem_data,
    output logic [30:0]       ir,
    input  logic              dec_wr_en,
    input  logic              dec_is_slp,
    input  logic              dec_is_jmp,
    input  logic [SLP_W-1:0]  slp_val,
    input  logic              tick,
    output logic              rf_wr_en,
    output logic              exec,
    output logic              sleeping,
    output logic [1:0]        state,
    output logic [PC_W-1:0]   pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        SLEEP = 2'd3
    } state_t;

    // Last valid program word and the program length widened by one bit so
    // that out-of-range jump targets (e.g. 15 with 14 words) compare cleanly.
    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W:0]   PROG_END = (PC_W + 1)'(PROG_LEN);

    state_t             cur_state;
    state_t             nxt_state;
    logic [PC_W-1:0]    pc_nxt;
    logic [30:0]        ir_nxt;
    logic [SLP_W-1:0]   slp_cnt;
    logic [SLP_W-1:0]   slp_cnt_nxt;
    logic [PC_W-1:0]    jmp_tgt;
    logic               jmp_ok;

    assign jmp_tgt = ir[PC_W-1:0];
    assign jmp_ok  = ({1'b0, jmp_tgt} < PROG_END);

    // State, pc, ir and sleep counter registers; reset discards any sleep or fetch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            pc        <= '0;
            ir        <= '0;
            slp_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed below, independent of statement order.
            cur_state <= nxt_state;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            slp_cnt   <= slp_cnt_nxt;
        end
    end

    // Next-state, next-pc, instruction capture and sleep countdown.
    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no
        // path through the case leaves one unassigned and no latch is inferred.
        nxt_state   = cur_state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        slp_cnt_nxt = slp_cnt;

        case (cur_state)
            IDLE: begin
                if (run) nxt_state = FETCH;
            end

            FETCH: begin
                ir_nxt    = imem_data;
                nxt_state = EXEC;
            end

            EXEC: begin
                // Jump wins over sequential advance; bad targets restart at 0.
                if (dec_is_jmp) begin
                    pc_nxt = jmp_ok ? jmp_tgt : '0;
                end else if (pc == LAST_PC) begin
                    pc_nxt = '0;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end

                // A jump suppresses sleep; a zero-length sleep is a NOP.
                if (!dec_is_jmp && dec_is_slp && (slp_val != '0)) begin
                    slp_cnt_nxt = slp_val;
                    nxt_state   = SLEEP;
                end else begin
                    nxt_state = run ? FETCH : IDLE;
                end
            end

            SLEEP: begin
                // run is not consulted until the final tick; the sleep always completes.
                if (tick) begin
                    if (slp_cnt <= SLP_W'(1)) begin
                        slp_cnt_nxt = '0;
                        nxt_state   = run ? FETCH : IDLE;
                    end else begin
                        slp_cnt_nxt = slp_cnt - SLP_W'(1);
                    end
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign exec      = (cur_state == EXEC);
    assign rf_wr_en  = (cur_state == EXEC) && dec_wr_en;
    assign sleeping  = (cur_state == SLEEP);
    assign state     = cur_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed + randomized check of cpu_sequencer against an
// instruction-level reference model (one task call per executed instruction).
module tb_cpu_sequencer;

    localparam int PC_W     = 4;
    localparam int PROG_LEN = 14;
    localparam int SLP_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [30:0]       imem_data;
    logic [30:0]       ir;
    logic              dec_wr_en;
    logic              dec_is_slp;
    logic              dec_is_jmp;
    logic [SLP_W-1:0]  slp_val;
    logic              tick;
    logic              rf_wr_en;
    logic              exec;
    logic              sleeping;
    logic [1:0]        state;
    logic [PC_W-1:0]   pc;

    // Test program ROM and the model's notion of the program counter.
    logic [30:0]       rom [16];
    logic [PC_W-1:0]   mpc;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .SLP_W(SLP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ir         (ir),
        .dec_wr_en  (dec_wr_en),
        .dec_is_slp (dec_is_slp),
        .dec_is_jmp (dec_is_jmp),
        .slp_val    (slp_val),
        .tick       (tick),
        .rf_wr_en   (rf_wr_en),
        .exec       (exec),
        .sleeping   (sleeping),
        .state      (state),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM clocked on the falling edge: data for the current
    // address is ready before the next rising edge.
    always @(negedge clk) imem_data <= rom[imem_addr];

    // Bench-side decoder. Word layout:
    // [30] jmp, [29] slp, [28] wr, [27:16] filler, [15:8] sleep operand, [7:4] filler, [3:0] target
    assign dec_is_jmp = ir[30];
    assign dec_is_slp = ir[29];
    assign dec_wr_en  = ir[28];
    assign slp_val    = ir[15:8];

    function automatic logic [30:0] mk(input bit jmp, input bit slp, input bit wr,
                                       input logic [7:0] sv, input logic [3:0] tgt,
                                       input logic [11:0] filler);
        return {jmp, slp, wr, filler, sv, 4'h0, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Execute one instruction at mpc and check every cycle of it. Entry and
    // exit: just after a rising edge, with the DUT expected to be in FETCH.
    // drop: lower run during EXEC; tick_per: sleep tick period (0 = random).
    task automatic do_instr(input bit drop, input int tick_per);
        logic [30:0] w;
        logic [3:0]  tgt;
        int          rem;
        int          per;
        int          cyc;

        check("fetch_state", state, 1);
        check("fetch_addr", imem_addr, mpc);
        check("fetch_rfwe", rf_wr_en, 0);
        tick = 1'($urandom_range(0, 1));    // must be ignored in FETCH
        step();

        w = rom[mpc];
        check("exec_flag", exec, 1);
        check("exec_ir", ir, w);
        check("exec_rfwe", rf_wr_en, w[28]);
        check("exec_pc", pc, mpc);

        tgt = w[3:0];
        if (w[30])
            mpc = (int'(tgt) < PROG_LEN) ? tgt : 4'd0;
        else
            mpc = (int'(mpc) == PROG_LEN - 1) ? 4'd0 : mpc + 4'd1;
        rem = (!w[30] && w[29]) ? int'(w[15:8]) : 0;

        tick = 1'($urandom_range(0, 1));    // must be ignored in EXEC
        if (drop) run = 1'b0;
        step();

        per = (tick_per > 0) ? tick_per : int'($urandom_range(1, 4));
        cyc = 0;
        while (rem > 0) begin
            check("slp_flag", sleeping, 1);
            check("slp_pc", pc, mpc);
            check("slp_ir", ir, w);
            check("slp_rfwe", rf_wr_en, 0);
            check("slp_exec", exec, 0);
            cyc++;
            tick = ((cyc % per) == 0);
            step();
            if (tick) rem--;
        end
        tick = 1'b0;
        check("post_sleeping", sleeping, 0);

        if (drop) begin
            check("idle_state", state, 0);
            check("idle_pc", pc, mpc);
            check("idle_ir", ir, w);
            step();
            check("idle_hold", state, 0);
            run = 1'b1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        tick  = 1'b0;
        mpc   = '0;

        for (int i = 0; i < 16; i++) rom[i] = mk(0, 0, 0, 8'h00, 4'(i), 12'h0A5);
        rom[0]  = mk(0, 0, 1, 8'h00, 4'h7, 12'h123);   // ADDI
        rom[1]  = mk(0, 0, 1, 8'h00, 4'hF, 12'h456);   // MOVRI
        rom[2]  = mk(0, 0, 0, 8'h00, 4'h3, 12'h000);   // NOP
        rom[3]  = mk(1, 0, 0, 8'h00, 4'h5, 12'h000);   // JMP 5
        rom[5]  = mk(0, 1, 0, 8'h03, 4'h0, 12'h000);   // SLP 3
        rom[6]  = mk(0, 1, 1, 8'h00, 4'h0, 12'h000);   // SLP 0 (acts as NOP)
        rom[7]  = mk(1, 1, 0, 8'h04, 4'h9, 12'h000);   // JMP 9 + SLP 4: jump only
        rom[9]  = mk(1, 0, 0, 8'h00, 4'hD, 12'h000);   // JMP 13
        rom[13] = mk(0, 0, 1, 8'h00, 4'h2, 12'h000);   // last word: wraps to 0

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_exec", exec, 0);
        check("rst_sleeping", sleeping, 0);
        check("rst_rfwe", rf_wr_en, 0);

        reset = 1'b0;
        step();
        check("idle_no_run", state, 0);
        run = 1'b1;
        step();

        // Words 0,1,2,3 -> 5 (sleep) -> 6 -> 7 -> 9 -> 13 -> wrap to 0
        repeat (9) do_instr(1'b0, 4);

        // JMP to an out-of-range target restarts at 0
        rom[2] = mk(1, 0, 0, 8'h00, 4'hF, 12'h000);
        repeat (3) do_instr(1'b0, 4);

        // Drop run during EXEC of word 0, then resume at word 1
        do_instr(1'b1, 4);

        // JMP 5 at pc=2, then reset while sleeping with two ticks outstanding
        rom[2] = mk(1, 0, 0, 8'h00, 4'h5, 12'h000);
        repeat (2) do_instr(1'b0, 4);
        check("rs_fetch_addr", imem_addr, 5);
        step();
        step();
        check("rs_sleeping", sleeping, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("rs_still_sleeping", sleeping, 1);
        #2 reset = 1'b1;
        #1;
        check("rs_state", state, 0);
        check("rs_pc", pc, 0);
        check("rs_ir", ir, 0);
        check("rs_sleeping_clr", sleeping, 0);
        check("rs_exec", exec, 0);
        step();
        reset = 1'b0;
        mpc   = '0;
        step();

        // Randomized program: ALU ops, jumps (some out of range), sleeps, combos
        for (int i = 0; i < PROG_LEN; i++) begin
            case ($urandom_range(0, 3))
                0: rom[i] = mk(0, 0, 1'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));
                1: rom[i] = mk(1, 0, 1'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));
                2: rom[i] = mk(0, 1, 1'($urandom), 8'($urandom_range(0, 5)), 4'($urandom), 12'($urandom));
                default: rom[i] = mk(1, 1, 1'($urandom), 8'($urandom_range(1, 5)), 4'($urandom), 12'($urandom));
            endcase
        end
        for (int n = 0; n < 60; n++) do_instr($urandom_range(0, 7) == 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
